// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cam_pkg
//  Description : Shared types and constants for the camera ring controller.
//                Holds the per-camera state encoding, the full-buffer
//                percentage and a constant function that validates a
//                parameter set at elaboration time.
//  Revision    : 1.0  initial release
// ============================================================================
package cam_pkg;

    // Per-camera state codes. Codes 5..7 are illegal and recover to IDLE.
    typedef enum logic [2:0] {
        CAM_IDLE    = 3'd0,
        CAM_STANDBY = 3'd1,
        CAM_FILMING = 3'd2,
        CAM_HOLD    = 3'd3,
        CAM_DRAIN   = 3'd4
    } cam_state_e;

    localparam int PCT_MAX = 100;

    // True when the parameter set describes a buildable ring.
    function automatic bit cfg_ok(input int num_cams, input int pct_w,
                                  input int step, input int standby_pct,
                                  input int handoff_pct, input int flush_pct,
                                  input int start_cam);
        return (num_cams >= 2) && (num_cams <= 8)
            && (pct_w >= 7)
            && (step > 0) && (step <= PCT_MAX) && ((PCT_MAX % step) == 0)
            && (standby_pct <= handoff_pct) && (handoff_pct <= PCT_MAX)
            && (flush_pct <= PCT_MAX)
            && (start_cam >= 0) && (start_cam < num_cams);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cam_channel.sv
`default_nettype none
// ============================================================================
//  Module      : cam_channel
//  Description : One camera of the ring: state register and fill counter.
//                All changes happen on a tick except illegal-code recovery.
//  Ports       : clock, reset_n     - clock, async active-low reset
//                tick               - fill/drain rate enable
//                start_film         - become the filming camera
//                go_hold            - stop filming and hold the buffer
//                go_standby         - warn an idle camera of upcoming handoff
//                flush              - discard a held buffer
//                download           - start draining a held buffer
//                state, pct         - registered state code and fill percent
//                fill_next          - fill level after one filming step
//                hold               - registered "state is HOLD" flag
//  Revision    : 1.0  initial release
// ============================================================================
module cam_channel
    import cam_pkg::*;
#(
    parameter int PCT_W    = 7,
    parameter int STEP     = 10,
    parameter bit IS_START = 1'b0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             start_film,
    input  logic             go_hold,
    input  logic             go_standby,
    input  logic             flush,
    input  logic             download,
    output logic [2:0]       state,
    output logic [PCT_W-1:0] pct,
    output logic [PCT_W-1:0] fill_next,
    output logic             hold
);

    localparam logic [PCT_W:0]   c_step_w  = (PCT_W + 1)'(STEP);
    localparam logic [PCT_W:0]   c_max_w   = (PCT_W + 1)'(PCT_MAX);
    localparam logic [PCT_W-1:0] c_step    = PCT_W'(STEP);
    localparam logic [PCT_W-1:0] c_max     = PCT_W'(PCT_MAX);
    localparam cam_state_e       c_rst_st  = IS_START ? CAM_FILMING : CAM_IDLE;

    cam_state_e       state_q, state_d;
    logic [PCT_W-1:0] pct_q, pct_d;
    logic             hold_q;
    logic [PCT_W:0]   w_sum;

    // One extra bit so the sum cannot wrap before it is clamped.
    assign w_sum     = {1'b0, pct_q} + c_step_w;
    assign fill_next = (w_sum > c_max_w) ? c_max : w_sum[PCT_W-1:0];

    always_comb begin
        state_d = state_q;
        pct_d   = pct_q;
        case (state_q)
            CAM_IDLE: begin
                if (tick && start_film)      state_d = CAM_FILMING;
                else if (tick && go_standby) state_d = CAM_STANDBY;
            end
            CAM_STANDBY: begin
                if (tick && start_film) state_d = CAM_FILMING;
            end
            CAM_FILMING: begin
                if (tick) begin
                    pct_d = fill_next;
                    if (go_hold) state_d = CAM_HOLD;
                end
            end
            CAM_HOLD: begin
                // A download on the same tick as a flush keeps the data.
                if (tick && download) begin
                    state_d = CAM_DRAIN;
                end else if (tick && flush) begin
                    state_d = CAM_IDLE;
                    pct_d   = '0;
                end
            end
            CAM_DRAIN: begin
                if (tick) begin
                    if (pct_q <= c_step) begin
                        pct_d   = '0;
                        state_d = CAM_IDLE;
                    end else begin
                        pct_d = pct_q - c_step;
                    end
                end
            end
            default: begin
                state_d = CAM_IDLE;
                pct_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= c_rst_st;
            pct_q   <= '0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pct_q   <= pct_d;
            hold_q  <= (state_d == CAM_HOLD);
        end
    end

    assign state = state_q;
    assign pct   = pct_q;
    assign hold  = hold_q;

endmodule
`default_nettype wire

// File: rtl/camera_ring_controller.sv
`default_nettype none
// ============================================================================
//  Module      : camera_ring_controller
//  Description : Buffer handoff controller for NUM_CAMS cameras in a ring.
//                Exactly one camera films; it warns and then hands off to its
//                successor, leaving its own buffer held for download or flush.
//  Ports       : clock, reset_n        - clock, async active-low reset
//                tick                  - fill/drain rate enable
//                download[N]           - per-camera download request
//                pct[N*PCT_W]          - per-camera fill percent
//                cam_state[N*3]        - per-camera state code
//                active_cam            - index of the filming camera
//                ready_to_download[N]  - camera is in HOLD
//                overrun               - sticky, handoff blocked at full buffer
//  Revision    : 1.0  initial release
// ============================================================================
module camera_ring_controller
    import cam_pkg::*;
#(
    parameter int NUM_CAMS    = 2,
    parameter int PCT_W       = 7,
    parameter int STEP        = 10,
    parameter int STANDBY_PCT = 80,
    parameter int HANDOFF_PCT = 90,
    parameter int FLUSH_PCT   = 50,
    parameter int START_CAM   = 0
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        tick,
    input  logic [NUM_CAMS-1:0]         download,
    output logic [NUM_CAMS*PCT_W-1:0]   pct,
    output logic [NUM_CAMS*3-1:0]       cam_state,
    output logic [$clog2(NUM_CAMS)-1:0] active_cam,
    output logic [NUM_CAMS-1:0]         ready_to_download,
    output logic                        overrun
);

    localparam int               AW            = $clog2(NUM_CAMS);
    localparam logic [PCT_W-1:0] c_standby_pct = PCT_W'(STANDBY_PCT);
    localparam logic [PCT_W-1:0] c_handoff_pct = PCT_W'(HANDOFF_PCT);
    localparam logic [PCT_W-1:0] c_flush_pct   = PCT_W'(FLUSH_PCT);
    localparam logic [PCT_W-1:0] c_pct_max     = PCT_W'(PCT_MAX);

    if (!cfg_ok(NUM_CAMS, PCT_W, STEP, STANDBY_PCT, HANDOFF_PCT, FLUSH_PCT,
                START_CAM)) begin : g_bad_cfg
        $error("camera_ring_controller: illegal parameter set");
    end

    logic [AW-1:0]                   active_q, active_d;
    logic                            overrun_q, overrun_d;

    logic [NUM_CAMS-1:0][2:0]        w_state;
    logic [NUM_CAMS-1:0][PCT_W-1:0]  w_pct;
    logic [NUM_CAMS-1:0][PCT_W-1:0]  w_fill;
    logic [NUM_CAMS-1:0]             w_hold;
    logic [AW-1:0]                   w_succ;
    logic [PCT_W-1:0]                w_act_fill;
    logic [2:0]                      w_succ_state;
    logic                            w_at_handoff;
    logic                            w_succ_free;
    logic                            w_succ_busy;
    logic                            w_handoff;
    logic                            w_want_standby;

    // Thresholds are judged on the fill the filming camera reaches this tick,
    // so the warning and the handoff land on the tick that crosses them.
    always_comb begin
        w_succ         = (active_q == AW'(NUM_CAMS - 1)) ? '0 : active_q + 1'b1;
        w_act_fill     = w_fill[active_q];
        w_succ_state   = w_state[w_succ];
        w_at_handoff   = tick && (w_act_fill >= c_handoff_pct);
        w_succ_free    = (w_succ_state == CAM_IDLE) || (w_succ_state == CAM_STANDBY);
        w_succ_busy    = (w_succ_state == CAM_HOLD) || (w_succ_state == CAM_DRAIN);
        w_handoff      = w_at_handoff && w_succ_free;
        w_want_standby = (w_act_fill >= c_standby_pct);
        active_d       = w_handoff ? w_succ : active_q;
        overrun_d      = overrun_q
                       || (w_at_handoff && w_succ_busy && (w_act_fill == c_pct_max));
    end

    for (genvar i = 0; i < NUM_CAMS; i++) begin : g_cam
        localparam int NXT = (i + 1) % NUM_CAMS;

        cam_channel #(
            .PCT_W    (PCT_W),
            .STEP     (STEP),
            .IS_START (i == START_CAM)
        ) u_chan (
            .clock      (clock),
            .reset_n    (reset_n),
            .tick       (tick),
            .start_film (w_handoff && (w_succ == AW'(i))),
            .go_hold    (w_handoff && (active_q == AW'(i))),
            .go_standby (w_want_standby && (w_succ == AW'(i))),
            // A held buffer is dropped once the camera after it has filmed
            // far enough; only that camera's projected fill matters.
            .flush      ((w_state[NXT] == CAM_FILMING) && (w_fill[NXT] >= c_flush_pct)),
            .download   (download[i]),
            .state      (w_state[i]),
            .pct        (w_pct[i]),
            .fill_next  (w_fill[i]),
            .hold       (w_hold[i])
        );

        assign pct[i*PCT_W +: PCT_W] = w_pct[i];
        assign cam_state[i*3 +: 3]   = w_state[i];
        assign ready_to_download[i]  = w_hold[i];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            active_q  <= AW'(START_CAM);
            overrun_q <= 1'b0;
        end else begin
            active_q  <= active_d;
            overrun_q <= overrun_d;
        end
    end

    assign active_cam = active_q;
    assign overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_camera_ring_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_camera_ring_controller
//  Description : Self-checking bench for camera_ring_controller. A two-camera
//                and a three-camera ring share clock, reset and tick; a
//                ring-level reference model predicts every output.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_camera_ring_controller;

    localparam int STEP = 10, STANDBY = 80, HANDOFF = 90, FLUSH = 50, PMAX = 100;
    localparam int S_IDLE = 0, S_STBY = 1, S_FILM = 2, S_HOLD = 3, S_DRAIN = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        tick = 1'b0;
    logic [1:0]  dl2 = '0;
    logic [2:0]  dl3 = '0;

    logic [13:0] d2_pct;
    logic [5:0]  d2_state;
    logic [0:0]  d2_act;
    logic [1:0]  d2_ready;
    logic        d2_ovr;
    logic [20:0] d3_pct;
    logic [8:0]  d3_state;
    logic [1:0]  d3_act;
    logic [2:0]  d3_ready;
    logic        d3_ovr;

    int checks = 0;
    int errors = 0;

    int m_n[2] = '{2, 3};
    int m_st[2][8];
    int m_pc[2][8];
    int m_act[2];
    int m_ovr[2];

    always #5 clk = ~clk;

    camera_ring_controller #(.NUM_CAMS(2)) u_dut2 (
        .clock(clk), .reset_n(reset_n), .tick(tick), .download(dl2),
        .pct(d2_pct), .cam_state(d2_state), .active_cam(d2_act),
        .ready_to_download(d2_ready), .overrun(d2_ovr)
    );

    camera_ring_controller #(.NUM_CAMS(3)) u_dut3 (
        .clock(clk), .reset_n(reset_n), .tick(tick), .download(dl3),
        .pct(d3_pct), .cam_state(d3_state), .active_cam(d3_act),
        .ready_to_download(d3_ready), .overrun(d3_ovr)
    );

    function automatic int dut_st(input int k, input int i);
        if (k == 0) return int'(d2_state[i*3 +: 3]);
        return int'(d3_state[i*3 +: 3]);
    endfunction

    function automatic int dut_pc(input int k, input int i);
        if (k == 0) return int'(d2_pct[i*7 +: 7]);
        return int'(d3_pct[i*7 +: 7]);
    endfunction

    function automatic int dut_rdy(input int k, input int i);
        if (k == 0) return int'(d2_ready[i]);
        return int'(d3_ready[i]);
    endfunction

    function automatic int dut_act(input int k);
        if (k == 0) return int'(d2_act);
        return int'(d3_act);
    endfunction

    function automatic int dut_ovr(input int k);
        if (k == 0) return int'(d2_ovr);
        return int'(d3_ovr);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) begin
                m_st[k][i] = S_IDLE;
                m_pc[k][i] = 0;
            end
            m_st[k][0] = S_FILM;
            m_act[k]   = 0;
            m_ovr[k]   = 0;
        end
    endtask

    // One tick of ring k, computed from the previous snapshot of the ring.
    task automatic model_tick(input int k, input logic [7:0] dl);
        int n, a, s, nf;
        int ost[8];
        int opc[8];
        n = m_n[k];
        a = m_act[k];
        s = (a + 1) % n;
        for (int i = 0; i < 8; i++) begin
            ost[i] = m_st[k][i];
            opc[i] = m_pc[k][i];
        end
        nf = (opc[a] + STEP > PMAX) ? PMAX : opc[a] + STEP;
        for (int i = 0; i < n; i++) begin
            if (ost[i] == S_HOLD) begin
                if (dl[i]) begin
                    m_st[k][i] = S_DRAIN;
                end else if (((i + 1) % n == a) && (nf >= FLUSH)) begin
                    m_st[k][i] = S_IDLE;
                    m_pc[k][i] = 0;
                end
            end else if (ost[i] == S_DRAIN) begin
                m_pc[k][i] = (opc[i] - STEP <= 0) ? 0 : opc[i] - STEP;
                if (m_pc[k][i] == 0) m_st[k][i] = S_IDLE;
            end
        end
        m_pc[k][a] = nf;
        if (nf >= HANDOFF) begin
            if (ost[s] == S_IDLE || ost[s] == S_STBY) begin
                m_st[k][s] = S_FILM;
                m_st[k][a] = S_HOLD;
                m_act[k]   = s;
            end else if (nf == PMAX) begin
                m_ovr[k] = 1;
            end
        end else if (nf >= STANDBY && ost[s] == S_IDLE) begin
            m_st[k][s] = S_STBY;
        end
    endtask

    task automatic compare_all();
        int films;
        for (int k = 0; k < 2; k++) begin
            films = 0;
            for (int i = 0; i < m_n[k]; i++) begin
                chk($sformatf("d%0d_state%0d", k, i), dut_st(k, i), m_st[k][i]);
                chk($sformatf("d%0d_pct%0d", k, i), dut_pc(k, i), m_pc[k][i]);
                chk($sformatf("d%0d_ready%0d", k, i), dut_rdy(k, i),
                    (m_st[k][i] == S_HOLD) ? 1 : 0);
                if (dut_st(k, i) == S_FILM) films++;
            end
            chk($sformatf("d%0d_one_filming", k), films, 1);
            chk($sformatf("d%0d_active", k), dut_act(k), m_act[k]);
            chk($sformatf("d%0d_overrun", k), dut_ovr(k), m_ovr[k]);
        end
    endtask

    // Called at a falling edge; drives inputs, advances the model at the
    // rising edge and compares at the next falling edge.
    task automatic step(input logic t, input logic [1:0] a, input logic [2:0] b);
        tick = t;
        dl2  = a;
        dl3  = b;
        @(posedge clk);
        if (t) begin
            model_tick(0, {6'b0, a});
            model_tick(1, {5'b0, b});
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic ticks(input int count);
        for (int j = 0; j < count; j++) step(1'b1, 2'b00, 3'b000);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick    = 1'b0;
        dl2     = '0;
        dl3     = '0;
        repeat (2) @(negedge clk);
        model_reset();
        reset_n = 1'b1;
        compare_all();
    endtask

    initial begin
        logic [1:0] r2;
        logic [2:0] r3;
        @(negedge clk);
        do_reset();
        chk("pu_state0", dut_st(0, 0), S_FILM);
        chk("pu_pct0", dut_pc(0, 0), 0);
        chk("pu_active", dut_act(0), 0);

        // Warning at 80, handoff at 90, flush when successor reaches 50.
        ticks(8);
        chk("sb_pct0", dut_pc(0, 0), 80);
        chk("sb_state1", dut_st(0, 1), S_STBY);
        ticks(1);
        chk("ho_state1", dut_st(0, 1), S_FILM);
        chk("ho_state0", dut_st(0, 0), S_HOLD);
        chk("ho_ready", int'(d2_ready), 1);
        chk("ho_active", dut_act(0), 1);
        chk("ho_pct0", dut_pc(0, 0), 90);
        ticks(5);
        chk("fl_pct1", dut_pc(0, 1), 50);
        chk("fl_state0", dut_st(0, 0), S_IDLE);
        chk("fl_pct0", dut_pc(0, 0), 0);

        // Ring order on the three-camera ring: 1 -> 2 -> 0.
        ticks(4);
        chk("ring_active2", dut_act(1), 2);
        ticks(9);
        chk("ring_active0", dut_act(1), 0);

        // Download on the exact flush tick wins, then drains 80..0.
        ticks(4);
        step(1'b1, 2'b00, 3'b100);
        chk("dl_state2", dut_st(1, 2), S_DRAIN);
        chk("dl_pct2", dut_pc(1, 2), 90);
        ticks(8);
        chk("dr_pct2", dut_pc(1, 2), 10);
        chk("dr_state2", dut_st(1, 2), S_DRAIN);
        ticks(1);
        chk("dr_done_pct2", dut_pc(1, 2), 0);
        chk("dr_done_state2", dut_st(1, 2), S_IDLE);

        // Overrun on the two-camera ring: successor still draining at 90.
        do_reset();
        ticks(9);
        step(1'b1, 2'b01, 3'b000);
        ticks(8);
        chk("ov_blocked_active", dut_act(0), 1);
        chk("ov_not_yet", int'(d2_ovr), 0);
        ticks(1);
        chk("ov_set", int'(d2_ovr), 1);
        chk("ov_pct1", dut_pc(0, 1), 100);
        ticks(1);
        chk("ov_late_active", dut_act(0), 0);
        chk("ov_sticky", int'(d2_ovr), 1);

        // Asynchronous reset in the middle of a drain.
        step(1'b1, 2'b10, 3'b000);
        ticks(2);
        chk("mid_state1", dut_st(0, 1), S_DRAIN);
        chk("mid_pct1", dut_pc(0, 1), 80);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_state0", dut_st(0, 0), S_FILM);
        chk("ar_state1", dut_st(0, 1), S_IDLE);
        chk("ar_pct1", dut_pc(0, 1), 0);
        chk("ar_active", dut_act(0), 0);
        chk("ar_overrun", int'(d2_ovr), 0);
        chk("ar_ready", int'(d2_ready), 0);
        model_reset();
        compare_all();
        @(negedge clk);
        reset_n = 1'b1;

        // Randomised operation against the model.
        for (int c = 0; c < 800; c++) begin
            for (int b = 0; b < 2; b++) r2[b] = ($urandom_range(0, 5) == 0);
            for (int b = 0; b < 3; b++) r3[b] = ($urandom_range(0, 5) == 0);
            step($urandom_range(0, 3) != 0, r2, r3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/camera_ring_controller.md
Name: camera_ring_controller

Overview:
- Generalised multi-camera buffer handoff controller for N cameras arranged in a ring.
- Exactly one camera films at a time. At a standby threshold the filming camera warns its successor; at a handoff threshold the successor starts filming.
- The predecessor then holds its data for download, or is flushed once the successor reaches a flush threshold.
- Sits between the user-input synchronisers and the HEX/LED/Qsys export logic. Replaces the fixed two-camera pair with a parametrised ring and adds download-drain, overrun detection and a tick enable.

Parameters:
- NUM_CAMS, 2: cameras in the ring, 2..8.
- PCT_W, 7: width of each percent field; holds 0..100.
- STEP, 10: percent added or removed per tick; 100 must be divisible by STEP.
- STANDBY_PCT, 80: fill level at which the successor is sent to STANDBY.
- HANDOFF_PCT, 90: fill level at which the successor starts FILMING.
- FLUSH_PCT, 50: successor fill level at which an undownloaded HOLD buffer is flushed.
- START_CAM, 0: camera that films after reset.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- tick  in  1  single-cycle fill/drain rate enable, from the clock divider
- download  in  NUM_CAMS  per-camera download request, synchronised, level
- pct  out  NUM_CAMS*PCT_W  per-camera fill percent, camera i at bits [i*PCT_W +: PCT_W]
- cam_state  out  NUM_CAMS*3  per-camera state code
- active_cam  out  $clog2(NUM_CAMS)  index of the filming camera
- ready_to_download  out  NUM_CAMS  1 while camera is in HOLD
- overrun  out  1  sticky; filming buffer hit 100 while the successor was not available

Behaviour:
- State codes: IDLE=0, STANDBY=1, FILMING=2, HOLD=3, DRAIN=4. Codes 5..7 are illegal and recover to IDLE on the next clock.
- All outputs are registered. Every state and pct change occurs on the clock edge where tick=1, unless stated otherwise.
- Reset (async assert, sync release):
  - START_CAM resets to FILMING, pct=0; all other cameras reset to IDLE, pct=0.
  - active_cam=START_CAM, overrun=0, ready_to_download=0.
  - Reset mid-operation discards all buffer contents.
- Successor: succ = (active_cam+1) mod NUM_CAMS.
- FILMING: pct += STEP per tick, saturating at 100.
- Standby: when the filming pct >= STANDBY_PCT and succ is IDLE, succ → STANDBY on that tick.
- Handoff: when the filming pct >= HANDOFF_PCT and succ is STANDBY or IDLE:
  - succ → FILMING, pct unchanged (0); current camera → HOLD; active_cam ← succ.
  - All of this happens in the same tick.
- Overrun: if succ is HOLD or DRAIN at the handoff threshold, the current camera keeps filming and saturates at 100.
  - overrun sets when pct reaches 100 under this condition; it clears only on reset.
  - Handoff fires on the first tick where succ is IDLE/STANDBY.
- HOLD:
  - pct frozen; ready_to_download=1.
  - download[i]=1 on a tick → DRAIN.
- DRAIN: pct -= STEP per tick. On the tick where pct would reach 0, pct=0 and state → IDLE. download is ignored in DRAIN.
- Flush: when a camera is in HOLD and its successor (i+1 mod N) is FILMING with pct >= FLUSH_PCT:
  - pct ← 0 and state → IDLE on that tick.
  - Flush is instantaneous; it does not step down.
- Simultaneous download and flush on the same tick: download wins (→ DRAIN).
- A download request to a camera that is not in HOLD has no effect.
- Invariant: exactly one camera is FILMING at all times after reset release.
- Width rules:
  - Additions are computed at PCT_W+1 bits, then clamped to 100.
  - Subtractions are clamped at 0; no wrap-around.
- No tick: no state or pct changes at all, apart from illegal-code recovery.

Decomposition:
- Package cam_pkg: cam_state_e enum (five codes above), PCT_MAX=100 constant, and STEP/threshold legality checks as elaboration assertions.
- Sub-module cam_channel, one per camera via generate:
  - holds that camera's state register and pct counter;
  - inputs: tick, start_film, go_standby, flush, download;
  - outputs: state, pct.
- The top holds active_cam, the successor and handoff arbitration, and overrun.

Test Plan:
- Power-up (defaults, N=2): release reset → cam0 FILMING, pct0=0; after 8 ticks pct0=80 and cam1=STANDBY.
- Handoff and flush: 9th tick → cam1 FILMING, cam0 HOLD, ready_to_download=2'b01, active_cam=1; 5 more ticks → pct1=50, cam0 IDLE, pct0=0.
- Download drain: from cam0 HOLD at 90, assert download[0] one tick before pct1 reaches 50 → cam0 DRAIN; pct0 goes 80…0 over 9 ticks, then IDLE. Download asserted on the exact flush tick → DRAIN, not flush.
- Overrun (N=2): hold cam1 in HOLD by asserting no download and forcing FLUSH_PCT=100 → filming cam saturates at 100 and overrun=1; overrun persists until reset_n=0.
- Ring order (NUM_CAMS=3): run 3 handoffs → active_cam sequence 0→1→2→0; no two cameras FILMING on any cycle (assertion).
- Async reset mid-DRAIN: reset_n low between clock edges → outputs return to reset values immediately, without a clock edge.
